// File: rtl/color_cycle_monitor.sv
// color_cycle_monitor: glitch-filtered checker of the R>Y>G>C>B>M colour cycle; in clk/reset/red_in/green_in/blue_in, out color/color_valid/step/locked/seq_error/timing_error/dwell_count/error_count
module color_cycle_monitor #(
  parameter int BLINK_INTERVAL = 2000000,
  parameter int TOLERANCE = 16,
  parameter int STABLE_CYCLES = 4,
  localparam int DW = $clog2(BLINK_INTERVAL + TOLERANCE + 1) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          red_in,
  input  logic          green_in,
  input  logic          blue_in,
  output logic [2:0]    color,
  output logic          color_valid,
  output logic          step,
  output logic          locked,
  output logic          seq_error,
  output logic          timing_error,
  output logic [DW-1:0] dwell_count,
  output logic [7:0]    error_count
);
  localparam int HW = $clog2(STABLE_CYCLES + 1) + 1;
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;
  state_t r_state, w_next;
  logic [2:0] r_samp, r_acc, w_in, w_succ_rgb, w_code;
  logic [HW-1:0] r_hold;
  logic w_acc, w_legal, w_succ, w_in_tol, w_stall, w_seq, w_tim;
  always_comb begin
    w_in = {red_in, green_in, blue_in};
    w_succ_rgb = r_acc == 3'b100 ? 3'b110 : r_acc == 3'b110 ? 3'b010 : r_acc == 3'b010 ? 3'b011 :
                 r_acc == 3'b011 ? 3'b001 : r_acc == 3'b001 ? 3'b101 : r_acc == 3'b101 ? 3'b100 : 3'b000;
    w_code = r_samp == 3'b100 ? 3'b010 : r_samp == 3'b110 ? 3'b011 : r_samp == 3'b011 ? 3'b101 :
             r_samp == 3'b001 ? 3'b001 : r_samp == 3'b101 ? 3'b100 : 3'b000;
    w_acc = r_hold == HW'(STABLE_CYCLES) && r_samp != r_acc;
    w_legal = r_samp != 3'b000 && r_samp != 3'b111;
    w_succ = w_legal && r_samp == w_succ_rgb;
    w_in_tol = int'(dwell_count) >= BLINK_INTERVAL - TOLERANCE && int'(dwell_count) <= BLINK_INTERVAL + TOLERANCE;
    w_stall = r_state == LOCKED && !w_acc && dwell_count == DW'(BLINK_INTERVAL + TOLERANCE);
    w_seq = w_acc && r_state != SEARCH && !w_succ;
    w_tim = !w_seq && (w_stall || (w_acc && r_state == LOCKED && !w_in_tol));
    w_next = !w_acc ? (w_stall ? SEARCH : r_state) : !w_legal ? SEARCH : r_state == SEARCH ? ACQUIRE :
             !w_succ ? ACQUIRE : (r_state == ACQUIRE || w_in_tol) ? LOCKED : ACQUIRE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SEARCH;
      r_samp <= '0;
      r_acc <= '0;
      r_hold <= '0;
      color <= '0;
      color_valid <= 1'b0;
      step <= 1'b0;
      locked <= 1'b0;
      seq_error <= 1'b0;
      timing_error <= 1'b0;
      dwell_count <= '0;
      error_count <= '0;
    end else begin
      r_samp <= w_in;
      r_hold <= w_in != r_samp ? HW'(1) : r_hold == HW'(STABLE_CYCLES) ? r_hold : r_hold + 1'b1;
      r_state <= w_next;
      step <= w_acc;
      seq_error <= w_seq;
      timing_error <= w_tim;
      locked <= w_next == LOCKED;
      dwell_count <= w_acc ? DW'(1) : &dwell_count ? dwell_count : dwell_count + 1'b1;
      error_count <= (w_seq || w_tim) && error_count != 8'hff ? error_count + 1'b1 : error_count;
      if (w_acc) begin
        r_acc <= r_samp;
        color <= w_code;
        color_valid <= w_legal;
      end
    end
  end
endmodule
